uart_tx_ctrl: RTL and testbench

Transmit-side controller for the UART TX path. It accepts a parallel data word with a valid strobe and frames it onto the serial line as start, data LSB-first, optional parity, and stop. It sequences the bit counter, the parity computation and the output-bit select. It sits between the system-side TX FIFO read port and the UART TX pin. `clk` is the already-divided TX bit clock, so one clock equals one bit time.

---
 rtl/uart_tx_pkg.sv | 14 +
 rtl/uart_tx_serializer.sv | 31 +++
 rtl/uart_tx_ctrl.sv | 60 ++++++
 tb/tb_uart_tx_ctrl.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/uart_tx_pkg.sv
// uart_tx_pkg: shared state encodings and line-level constants for the UART TX path.
package uart_tx_pkg;
   typedef logic [2:0] state_t;
   localparam state_t IDLE   = 3'd0;
   localparam state_t START  = 3'd1;
   localparam state_t DATA   = 3'd2;
   localparam state_t PARITY = 3'd3;
   localparam state_t STOP   = 3'd4;
   localparam logic PAR_EVEN  = 1'b0;
   localparam logic PAR_ODD   = 1'b1;
   localparam logic LINE_IDLE = 1'b1;
   localparam logic START_BIT = 1'b0;
   localparam logic STOP_BIT  = 1'b1;
endpackage

// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: shadow data register and bit counter, shifting LSB-first.
module uart_tx_serializer #(
   parameter int DATA_WIDTH = 8,
   parameter int CNT_WIDTH  = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  load,
   input  logic [DATA_WIDTH-1:0] data,
   input  logic                  ser_en,
   output logic                  ser_bit,
   output logic                  ser_last
);
   logic [DATA_WIDTH-1:0] shadow;
   logic [CNT_WIDTH-1:0]  cnt;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shadow <= '0;
         cnt    <= '0;
      end else if (load) begin
         shadow <= data;
         cnt    <= '0;
      end else if (ser_en) begin
         shadow <= shadow >> 1;
         cnt    <= cnt + CNT_WIDTH'(1);
      end
   end
   assign ser_bit  = shadow[0];
   // cnt counts bits already placed on the line, so it equals DATA_WIDTH during the last data bit
   assign ser_last = cnt == CNT_WIDTH'(DATA_WIDTH);
endmodule

// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl: frames a parallel word as start, LSB-first data, optional parity and stop.
// Outputs are registered from the next state so each bit appears in the cycle its state is entered.
module uart_tx_ctrl
   import uart_tx_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int CNT_WIDTH  = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] p_data,
   input  logic                  d_valid,
   input  logic                  par_en,
   input  logic                  par_typ,
   output logic                  tx_out,
   output logic                  busy,
   output logic                  tx_done
);
   state_t state, next;
   logic par_bit, par_en_q, ser_bit, ser_last, load, tx_next;
   assign load = state == IDLE && d_valid;
   always_comb begin
      next = state == IDLE   ? (d_valid ? START : IDLE) :
             state == START  ? DATA :
             state == DATA   ? (ser_last ? (par_en_q ? PARITY : STOP) : DATA) :
             state == PARITY ? STOP : IDLE;
      tx_next = next == START  ? START_BIT :
                next == DATA   ? ser_bit :
                next == PARITY ? par_bit :
                next == STOP   ? STOP_BIT : LINE_IDLE;
   end
   uart_tx_serializer #(.DATA_WIDTH(DATA_WIDTH), .CNT_WIDTH(CNT_WIDTH)) u_ser (
      .clk(clk),
      .rst(rst),
      .load(load),
      .data(p_data),
      .ser_en(next == DATA),
      .ser_bit(ser_bit),
      .ser_last(ser_last)
   );
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         tx_out   <= LINE_IDLE;
         busy     <= 1'b0;
         tx_done  <= 1'b0;
         par_bit  <= PAR_EVEN;
         par_en_q <= 1'b0;
      end else begin
         state   <= next;
         tx_out  <= tx_next;
         busy    <= next != IDLE;
         tx_done <= state == STOP;
         if (load) begin
            par_en_q <= par_en;
            par_bit  <= (^p_data) ^ (par_typ == PAR_ODD);
         end
      end
   end
endmodule

// File: tb/tb_uart_tx_ctrl.sv
// tb_uart_tx_ctrl: scoreboard bench; expected line bits are queued at send time and popped per busy cycle.
module tb_uart_tx_ctrl;
   logic clk = 1'b0, rst = 1'b1;
   always #5 clk = ~clk;
   logic [7:0] p_data = '0;
   logic d_valid = 1'b0, par_en = 1'b0, par_typ = 1'b0;
   logic tx_out, busy, tx_done;
   logic [6:0] p7 = '0;
   logic dv7 = 1'b0, pe7 = 1'b0, pt7 = 1'b0;
   logic out7, busy7, done7;
   int n_chk = 0, n_pass = 0, blen = 0;
   bit bit_q[$];
   int len_q[$];
   bit q7[$];

   uart_tx_ctrl #(.DATA_WIDTH(8), .CNT_WIDTH(4)) dut (
      .clk(clk), .rst(rst), .p_data(p_data), .d_valid(d_valid), .par_en(par_en),
      .par_typ(par_typ), .tx_out(tx_out), .busy(busy), .tx_done(tx_done)
   );
   uart_tx_ctrl #(.DATA_WIDTH(7), .CNT_WIDTH(4)) dut7 (
      .clk(clk), .rst(rst), .p_data(p7), .d_valid(dv7), .par_en(pe7),
      .par_typ(pt7), .tx_out(out7), .busy(busy7), .tx_done(done7)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
   endtask

   function automatic bit par_of(input logic [8:0] d, input int w, input bit typ);
      int ones = 0;
      for (int i = 0; i < w; i++) ones += int'(d[i]);
      return bit'(ones % 2) ^ typ;
   endfunction

   task automatic push_frame(input logic [7:0] d, input bit pe, input bit pt);
      bit_q.push_back(1'b0);
      for (int i = 0; i < 8; i++) bit_q.push_back(d[i]);
      if (pe) bit_q.push_back(par_of({1'b0, d}, 8, pt));
      bit_q.push_back(1'b1);
      len_q.push_back(pe ? 11 : 10);
   endtask

   task automatic send(input logic [7:0] d, input bit pe, input bit pt);
      push_frame(d, pe, pt);
      p_data = d; par_en = pe; par_typ = pt; d_valid = 1'b1;
      @(posedge clk);
      #1 d_valid = 1'b0; p_data = ~d; par_en = !pe; par_typ = !pt;
   endtask

   task automatic wait_idle();
      int n = 0;
      while ((bit_q.size() != 0 || len_q.size() != 0) && n < 40) begin
         @(posedge clk);
         n++;
      end
      #1 check("wait_idle_in_budget", 32'(n < 40), 1);
   endtask

   always @(negedge clk) begin
      if (rst) blen = 0;
      else if (busy) begin
         check("overlap", tx_done, 0);
         if (bit_q.size() == 0) check("extra_bit", bit_q.size(), 1);
         else check("tx_bit", tx_out, bit_q.pop_front());
         blen++;
      end else if (blen != 0) begin
         check("tx_done", tx_done, 1);
         check("idle_line", tx_out, 1);
         if (len_q.size() == 0) check("extra_frame", len_q.size(), 1);
         else check("busy_len", blen, len_q.pop_front());
         blen = 0;
      end else begin
         check("no_done", tx_done, 0);
         check("idle_line", tx_out, 1);
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int n;
      repeat (2) @(posedge clk);
      #1;
      check("rst_tx_out", tx_out, 1);
      check("rst_busy", busy, 0);
      check("rst_done", tx_done, 0);
      check("rst_busy7", busy7, 0);
      rst = 1'b0;
      repeat (5) @(posedge clk);
      #1 check("idle_busy", busy, 0);
      send(8'hA5, 1'b0, 1'b0);
      wait_idle();
      send(8'h07, 1'b1, 1'b0);
      wait_idle();
      send(8'h07, 1'b1, 1'b1);
      wait_idle();
      push_frame(8'h00, 1'b0, 1'b0);
      push_frame(8'hFF, 1'b0, 1'b0);
      p_data = 8'h00; par_en = 1'b0; par_typ = 1'b0; d_valid = 1'b1;
      repeat (4) @(posedge clk);
      #1 p_data = 8'hFF;
      n = 0;
      while (!tx_done && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("b2b_done_in_budget", 32'(n < 20), 1);
      @(negedge clk);
      check("b2b_gap_one_cycle", busy, 1);
      @(posedge clk);
      #1 d_valid = 1'b0;
      wait_idle();
      send(8'h3C, 1'b0, 1'b0);
      repeat (4) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      check("midrst_tx_out", tx_out, 1);
      check("midrst_busy", busy, 0);
      check("midrst_done", tx_done, 0);
      bit_q.delete();
      len_q.delete();
      @(posedge clk);
      #1 rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      send(8'h3C, 1'b1, 1'b1);
      wait_idle();
      p7 = 7'h55; pe7 = 1'b1; pt7 = 1'b1;
      q7.push_back(1'b0);
      for (int i = 0; i < 7; i++) q7.push_back(p7[i]);
      q7.push_back(par_of({2'b0, p7}, 7, 1'b1));
      q7.push_back(1'b1);
      dv7 = 1'b1;
      @(posedge clk);
      #1 dv7 = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("w7_bit", out7, q7.pop_front());
         check("w7_busy", busy7, 1);
      end
      @(negedge clk);
      check("w7_done", done7, 1);
      check("w7_busy_end", busy7, 0);
      check("w7_line", out7, 1);
      repeat (2) @(posedge clk);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
